i2s_tx: RTL
===========

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: number of clk cycles per bclk half-period; legal values are 1..255.
REQ-002 Parameter FIFO_DEPTH, default 4: sample FIFO entries; must be a power of 2, at least 2.
REQ-003 clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  high runs the serial interface; low idles it.
REQ-006 sample_in  input  16  signed mono sample from the Echo output (two's complement).
REQ-007 sample_valid  input  1  sample_in is valid this cycle.
REQ-008 sample_ready  output  1  the FIFO can accept a sample this cycle.
REQ-009 bclk  output  1  I2S bit clock.
REQ-010 lrclk  output  1  I2S word select; 0 = left channel, 1 = right channel.
REQ-011 sdata  output  1  I2S serial data, MSB first.
REQ-012 underflow  output  1  one-clk pulse when a frame starts with the FIFO empty.

Function
REQ-013 Push happens when sample_valid && sample_ready; sample_ready = !fifo_full, registered-state combinational, with no dependency on sample_valid.
REQ-014 Divider counts 0..CLK_DIV-1 while enable is high; at terminal count bclk toggles and the divider returns to 0.
REQ-015 "Fall event" means the clk cycle in which bclk toggles 1->0; bit_cnt (5 bits, 0..31) advances on each fall event and wraps 31->0.
REQ-016 sdata, lrclk and bit_cnt update only on fall events, so they are stable at every bclk rising edge.
REQ-017 Frame: bit_cnt 0..15 drives left[15-bit_cnt]; bit_cnt 16..31 drives right[31-bit_cnt]; left and right both carry the same mono sample.
REQ-018 lrclk is 1 for bit_cnt 15..30 and 0 for bit_cnt 31 and 0..14, giving the standard one-bclk lead before each MSB.
REQ-019 On the fall event where bit_cnt wraps 31->0 (and on the first fall event after enable rises), one FIFO entry is popped into the frame register.
REQ-020 If the FIFO is empty at that pop point, the frame register keeps its previous sample and underflow pulses high for exactly one clk.
REQ-021 A push and a pop in the same cycle are both honoured and the level is unchanged; a push into an empty FIFO in the same cycle as a pop point does not bypass to the pop, so underflow occurs.
REQ-022 sample_ready is low when the FIFO is full; sample_valid while full is ignored and no data is overwritten.
REQ-023 FIFO read and write pointers wrap modulo FIFO_DEPTH; full and empty are distinguished with an extra pointer bit.
REQ-024 When enable is low: divider and bit_cnt are held at 0, bclk=0, lrclk=0, sdata=0, no pops occur; the FIFO keeps its contents and still accepts pushes.
REQ-025 When enable rises, the first fall event occurs CLK_DIV*2 clk cycles later and loads bit_cnt 0 with the MSB of the popped sample.
REQ-026 When enable falls mid-frame, the interface idles on the next clk and the partially sent sample is discarded.

Reset
REQ-027 While rst is low: bclk=0, lrclk=0, sdata=0, underflow=0, sample_ready=1, FIFO empty, frame register=0, divider=0, bit_cnt=0.
REQ-028 Reset asserted mid-frame clears all state immediately (asynchronously); deassertion is synchronised to clk.

Structure
REQ-029 Shared package audio_pkg holds: sample_t (signed 16), SAMPLE_W=16, FRAME_BITS=32.
REQ-030 The FIFO is a sub-module named sample_fifo (push, pop, din, dout, full, empty), instantiated once; the serializer FSM and the divider live in i2s_tx.

Verification
REQ-031 CLK_DIV=2, enable=1, push 16'h8001 -> bclk period is 4 clk; left and right each shift 1000_0000_0000_0001; lrclk rises exactly one bclk before the right MSB.
REQ-032 Push 4 samples with no pops -> sample_ready is 0 after the 4th push; a 5th push of 16'h1234 is dropped and never appears on sdata.
REQ-033 FIFO empty at frame start -> underflow high for 1 clk and the previous sample is re-sent bit-exact.
REQ-034 Push 16'hFFFF, 16'h0000, 16'h5A5A back-to-back -> three frames appear in order with no gaps and no underflow.
REQ-035 Drop enable at bit_cnt 7 -> bclk, lrclk and sdata are 0 on the next clk; re-enable -> the next FIFO sample starts at bit_cnt 0 after 2*CLK_DIV clk cycles.
REQ-036 Assert rst mid-frame with 3 entries in the FIFO -> all outputs are at their reset values immediately and sample_ready=1; after release, the FIFO is empty.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types for the I2S transmit path: mono sample type, frame
// geometry and the word-select decode used by the serializer.
package audio_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int FRAME_BITS = 32;

   typedef logic signed [SAMPLE_W-1:0]     sample_t;
   typedef logic [$clog2(FRAME_BITS)-1:0]  bit_cnt_t;

   typedef enum logic {
      SER_IDLE,
      SER_RUN
   } ser_state_e;

   // Word select leads the MSB of each channel by one bclk.
   function automatic logic lrclk_for(input bit_cnt_t cnt);
      return (cnt >= bit_cnt_t'(SAMPLE_W - 1)) && (cnt <= bit_cnt_t'(FRAME_BITS - 2));
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO, combinational read data at the head; zero-latency status.
// Pushes while full and pops while empty are ignored, so nothing is overwritten.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  logic    pop,
   input  sample_t din,
   output sample_t dout,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   sample_t     mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   // Extra pointer bit tells full from empty when the index bits match.
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty   = (wr_q == rd_q);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: FIFO-buffered mono samples sent as identical left/right words.
// Serial outputs change only when bclk falls; sample_ready drops while the FIFO is full.
module i2s_tx
   import audio_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                underflow
);

   localparam int DIV_W = 8;

   logic       rst_meta_q, rst_sync_q;
   logic       fifo_full, fifo_empty, fifo_pop;
   sample_t    fifo_dout;

   ser_state_e state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   bit_cnt_t   cnt_q, cnt_d, nxt_cnt;
   sample_t    frame_q, frame_d;
   logic       bclk_q, bclk_d;
   logic       lr_q, lr_d;
   logic       sd_q, sd_d;
   logic       und_q, und_d;
   logic       tc;

   // Reset asserts immediately, releases two clk edges later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_sync_q),
      .push  (sample_valid),
      .pop   (fifo_pop),
      .din   (sample_t'(sample_in)),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign sample_ready = !fifo_full;
   assign tc           = (div_q == DIV_W'(CLK_DIV - 1));

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bclk_d   = bclk_q;
      cnt_d    = cnt_q;
      lr_d     = lr_q;
      sd_d     = sd_q;
      frame_d  = frame_q;
      und_d    = 1'b0;
      fifo_pop = 1'b0;
      nxt_cnt  = cnt_q + 1'b1;
      if (!enable) begin
         state_d = SER_IDLE;
         div_d   = '0;
         bclk_d  = 1'b0;
         cnt_d   = '0;
         lr_d    = 1'b0;
         sd_d    = 1'b0;
      end else begin
         if (tc) begin
            div_d  = '0;
            bclk_d = !bclk_q;
         end else begin
            div_d  = div_q + 1'b1;
         end
         // Fall event; the first one after enable starts a fresh frame.
         if (tc && bclk_q) begin
            if (state_q == SER_IDLE) nxt_cnt = '0;
            state_d = SER_RUN;
            if (nxt_cnt == '0) begin
               if (fifo_empty) begin
                  und_d = 1'b1;
               end else begin
                  fifo_pop = 1'b1;
                  frame_d  = fifo_dout;
               end
            end
            cnt_d = nxt_cnt;
            lr_d  = lrclk_for(nxt_cnt);
            sd_d  = frame_d[4'd15 - nxt_cnt[3:0]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q <= SER_IDLE;
         div_q   <= '0;
         bclk_q  <= 1'b0;
         cnt_q   <= '0;
         lr_q    <= 1'b0;
         sd_q    <= 1'b0;
         frame_q <= '0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bclk_q  <= bclk_d;
         cnt_q   <= cnt_d;
         lr_q    <= lr_d;
         sd_q    <= sd_d;
         frame_q <= frame_d;
         und_q   <= und_d;
      end
   end

   assign bclk      = bclk_q;
   assign lrclk     = lr_q;
   assign sdata     = sd_q;
   assign underflow = und_q;

endmodule
